// File: rtl/univ_shift_reg.sv
// Universal shift register on falling clk edges: hold, shift right/left, parallel load,
// with a frame counter and a one-cycle done pulse every WIDTH shifts.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_n,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    typedef enum logic {
        EMPTY,
        FILLING
    } frame_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    frame_t           r_state;

    logic             w_shift;
    logic [WIDTH-1:0] w_shifted;

    always_comb begin
        w_shift   = (mode == 2'b01) || (mode == 2'b10);
        w_shifted = (mode == 2'b01) ? {sin_r, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], sin_l};
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q     <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_state <= EMPTY;
        end else if (!set_n) begin
            r_q     <= '1;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_state <= EMPTY;
        end else if (mode == 2'b11) begin
            r_q     <= d;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_state <= EMPTY;
        end else if (w_shift) begin
            r_q <= w_shifted;
            // Wrap is only reachable from FILLING since LAST is never 0 (WIDTH >= 2).
            if (r_state == FILLING && r_cnt == LAST) begin
                r_cnt   <= '0;
                r_done  <= 1'b1;
                r_state <= EMPTY;
            end else begin
                r_cnt   <= (r_state == EMPTY) ? CW'(1) : r_cnt + CW'(1);
                r_done  <= 1'b0;
                r_state <= FILLING;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign q      = r_q;
    assign cnt    = r_cnt;
    assign done   = r_done;
    assign sout_r = r_q[0];
    assign sout_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios with literal expectations plus random
// traffic, all checked every falling edge against a shift-count based model.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          set_n = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic          sin_r = 1'b0;
    logic          sin_l = 1'b0;
    logic [W-1:0]  d = '0;
    logic [W-1:0]  q;
    logic          sout_r, sout_l;
    logic [CW-1:0] cnt;
    logic          done;

    int unsigned total = 0;
    int unsigned bad = 0;

    // model: register value plus number of shifts since the last load/set/reset
    logic [W-1:0]  m_q = '0;
    int unsigned   m_shifts = 0;
    logic          m_done = 1'b0;
    bit            m_valid = 1'b0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .set_n(set_n), .mode(mode),
        .sin_r(sin_r), .sin_l(sin_l), .d(d), .q(q),
        .sout_r(sout_r), .sout_l(sout_l), .cnt(cnt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            m_q = '0; m_shifts = 0; m_done = 1'b0; m_valid = 1'b1;
        end else if (!set_n) begin
            m_q = '1; m_shifts = 0; m_done = 1'b0;
        end else begin
            case (mode)
                2'b11: begin m_q = d; m_shifts = 0; m_done = 1'b0; end
                2'b01: begin
                    m_q = (m_q >> 1) | (W'(sin_r) << (W - 1));
                    m_shifts++;
                    m_done = (m_shifts % W) == 0;
                end
                2'b10: begin
                    m_q = (m_q << 1) | W'(sin_l);
                    m_shifts++;
                    m_done = (m_shifts % W) == 0;
                end
                default: m_done = 1'b0;
            endcase
        end
        #1;
        if (m_valid) begin
            check("model_q", 32'(q), 32'(m_q));
            check("model_cnt", 32'(cnt), 32'(m_shifts % W));
            check("model_done", 32'(done), 32'(m_done));
            check("model_sout_r", 32'(sout_r), 32'(m_q[0]));
            check("model_sout_l", 32'(sout_l), 32'(m_q[W-1]));
        end
    end

    // Drive on the rising edge, return just after the falling edge and the model check.
    task automatic step(input logic s_n, input logic [1:0] md, input logic sr,
                        input logic sl, input logic [W-1:0] dd);
        @(posedge clk);
        set_n = s_n; mode = md; sin_r = sr; sin_l = sl; d = dd;
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        set_n = 1'b1; mode = 2'b00;
        @(negedge clk);
        @(posedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] stream;
        int unsigned pulses;

        // reset state
        @(negedge clk); @(negedge clk); #2;
        check("rst_q", 32'(q), 0);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_souts", {30'b0, sout_l, sout_r}, 0);
        @(posedge clk); reset_n = 1'b1;

        // async reset between edges
        step(1, 2'b11, 0, 0, 8'hA5);
        check("load_q", 32'(q), 32'hA5);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        check("async_q", 32'(q), 0);
        check("async_cnt", 32'(cnt), 0);
        check("async_done", 32'(done), 0);
        @(negedge clk); @(posedge clk); reset_n = 1'b1;

        // load then right-shift frame
        step(1, 2'b11, 0, 0, 8'hA5);
        pat = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            check("rshift_sout_r", 32'(sout_r), 32'(pat[i]));
            step(1, 2'b01, 0, 0, '0);
            if (i < 7) check("rshift_nodone", 32'(done), 0);
        end
        check("rshift_q", 32'(q), 0);
        check("rshift_done", 32'(done), 1);
        check("rshift_cnt", 32'(cnt), 0);
        step(1, 2'b00, 0, 0, '0);
        check("hold_after_done", 32'(done), 0);
        check("hold_after_done_cnt", 32'(cnt), 0);

        // serial-to-parallel left shift from reset
        do_reset();
        stream = 8'b1100_1011;
        for (int i = 0; i < 8; i++) begin
            step(1, 2'b10, 0, stream[7-i], '0);
            check("lshift_cnt", 32'(cnt), 32'((i + 1) % 8));
            check("lshift_done", 32'(done), (i == 7) ? 1 : 0);
        end
        check("lshift_q", 32'(q), 32'hCB);

        // set beats load mid-frame
        for (int i = 0; i < 3; i++) step(1, 2'b01, 1, 0, '0);
        check("pre_set_cnt", 32'(cnt), 3);
        step(0, 2'b11, 0, 0, 8'h12);
        check("set_q", 32'(q), 32'hFF);
        check("set_cnt", 32'(cnt), 0);
        check("set_done", 32'(done), 0);

        // hold, mixed directions, back-to-back frames
        for (int i = 0; i < 4; i++) step(1, 2'b01, 0, 0, '0);
        step(1, 2'b00, 0, 0, '0);
        check("hold_cnt_a", 32'(cnt), 4);
        step(1, 2'b00, 0, 0, '0);
        check("hold_cnt_b", 32'(cnt), 4);
        for (int i = 0; i < 4; i++) begin
            step(1, 2'b10, 0, 1, '0);
            check("mixed_done", 32'(done), (i == 3) ? 1 : 0);
        end
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1, (i % 3 == 0) ? 2'b10 : 2'b01, 1'($urandom), 1'($urandom), '0);
            if (done) pulses++;
            check("b2b_done", 32'(done), (i == 8 || i == 16) ? 1 : 0);
        end
        check("b2b_pulses", pulses, 2);

        // reset mid-frame discards the partial frame
        for (int i = 0; i < 5; i++) step(1, 2'b01, 0, 0, '0);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(1, 2'b10, 0, 1, '0);
            check("post_rst_done", 32'(done), (i == 8) ? 1 : 0);
        end

        // random traffic, checked by the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 15) != 0), 2'($urandom), 1'($urandom),
                     1'($urandom), W'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
